// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches words from an internal program RAM and issues them to
// the datapaths, advancing on completion. Define INSTR_SEQ_LOOP_EN to add the LOOP opcode (254).
module instr_sequencer #(
    parameter int ADDR_W = 11,
    parameter int OP_W   = 8,
    parameter int PROC_W = 3,
    parameter int MEM_W  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start_eth,
    input  logic [3*OP_W+PROC_W+MEM_W+1-1:0]      program_data_eth,
    input  logic [ADDR_W-1:0]                     program_address_eth,
    input  logic                                  program_data_load_eth,
    input  logic                                  instruction_computation_executed,
    input  logic                                  instruction_ddr_executed,
    output logic [OP_W-1:0]                       instruction,
    output logic [OP_W-1:0]                       operand1,
    output logic [OP_W-1:0]                       operand2,
    output logic [PROC_W-1:0]                     processor_sel,
    output logic [MEM_W-1:0]                      memory_sel,
    output logic                                  modulus_sel,
    output logic [ADDR_W-1:0]                     pc,
    output logic                                  busy,
    output logic                                  done
);

    // state  | meaning
    // IDLE   | not running, pc held at 0
    // FETCH  | pc presented to program RAM
    // ISSUE  | RAM word captured into the instruction register
    // WAIT   | fields driven, waiting for the matching completion
    // ADV    | fields forced to 0, pc updated
    // HALT   | opcode 255 reached, done=1 until start_eth drops

    localparam int WW             = 3*OP_W + PROC_W + MEM_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [OP_W-1:0] OPC_NOP   = '0;
    localparam logic [OP_W-1:0] OPC_DDR_A = OP_W'(3);
    localparam logic [OP_W-1:0] OPC_DDR_B = OP_W'(4);
    localparam logic [OP_W-1:0] OPC_HALT  = OP_W'(255);
`ifdef INSTR_SEQ_LOOP_EN
    localparam logic [OP_W-1:0] OPC_LOOP  = OP_W'(254);
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_ADV   = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [WW-1:0]       ir_q;
    logic [WW-1:0]       rdata_q;
    logic [WW-1:0]       prog_mem [DEPTH];

    logic [OP_W-1:0]     ir_op;
    logic [OP_W-1:0]     ir_op1;
    logic [OP_W-1:0]     ir_op2;
    logic [PROC_W-1:0]   ir_proc;
    logic [MEM_W-1:0]    ir_mem;
    logic                ir_mod;
    logic                is_loop;
    logic                is_ddr;

    assign ir_op   = ir_q[OP_W-1:0];
    assign ir_op1  = ir_q[2*OP_W-1:OP_W];
    assign ir_op2  = ir_q[3*OP_W-1:2*OP_W];
    assign ir_proc = ir_q[3*OP_W +: PROC_W];
    assign ir_mem  = ir_q[3*OP_W+PROC_W +: MEM_W];
    assign ir_mod  = ir_q[WW-1];
    assign is_ddr  = (ir_op == OPC_DDR_A) || (ir_op == OPC_DDR_B);

`ifdef INSTR_SEQ_LOOP_EN
    assign is_loop = (ir_op == OPC_LOOP);
`else
    assign is_loop = 1'b0;
`endif

    // Program RAM: no reset, read-first so a same-edge load returns the old word.
    always_ff @(posedge clk) begin
        if (program_data_load_eth) begin
            prog_mem[program_address_eth] <= program_data_eth;
        end
        if (state_q == S_FETCH) begin
            rdata_q <= prog_mem[pc_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (start_eth && (state_q == S_ISSUE)) begin
                ir_q <= rdata_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (!start_eth) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  state_d = S_FETCH;
                S_FETCH: state_d = S_ISSUE;
                S_ISSUE: state_d = S_WAIT;
                S_WAIT: begin
                    if (ir_op == OPC_HALT) begin
                        state_d = S_HALT;
                    end else if ((ir_op == OPC_NOP) || is_loop) begin
                        state_d = S_ADV;
                    end else if (is_ddr) begin
                        if (instruction_ddr_executed) state_d = S_ADV;
                    end else if (instruction_computation_executed) begin
                        state_d = S_ADV;
                    end
                end
                S_ADV:   state_d = S_FETCH;
                S_HALT:  state_d = S_HALT;
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef INSTR_SEQ_LOOP_EN
    logic [OP_W-1:0] loop_cnt_q, loop_cnt_d;
    logic            loop_armed_q, loop_armed_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loop_cnt_q   <= '0;
            loop_armed_q <= 1'b0;
        end else begin
            loop_cnt_q   <= loop_cnt_d;
            loop_armed_q <= loop_armed_d;
        end
    end

    always_comb begin
        pc_d         = pc_q;
        loop_cnt_d   = loop_cnt_q;
        loop_armed_d = loop_armed_q;
        if (!start_eth || (state_q == S_IDLE)) begin
            pc_d         = '0;
            loop_cnt_d   = '0;
            loop_armed_d = 1'b0;
        end else if (state_q == S_ADV) begin
            pc_d = pc_q + ADDR_W'(1);
            if (is_loop) begin
                // Only one loop may be active; an armed LOOP always refers to itself.
                if (!loop_armed_q) begin
                    loop_cnt_d = ir_op1;
                    if (ir_op1 != '0) begin
                        loop_cnt_d   = ir_op1 - OP_W'(1);
                        loop_armed_d = 1'b1;
                        pc_d         = pc_q - ADDR_W'(ir_op2);
                    end
                end else if (loop_cnt_q != '0) begin
                    loop_cnt_d = loop_cnt_q - OP_W'(1);
                    pc_d       = pc_q - ADDR_W'(ir_op2);
                end else begin
                    loop_armed_d = 1'b0;
                end
            end
        end
    end
`else
    always_comb begin
        pc_d = pc_q;
        if (!start_eth || (state_q == S_IDLE)) begin
            pc_d = '0;
        end else if (state_q == S_ADV) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end
`endif

    always_comb begin
        instruction   = '0;
        operand1      = '0;
        operand2      = '0;
        processor_sel = '0;
        memory_sel    = '0;
        modulus_sel   = 1'b0;
        if ((state_q == S_WAIT) && !is_loop) begin
            instruction   = ir_op;
            operand1      = ir_op1;
            operand2      = ir_op2;
            processor_sel = ir_proc;
            memory_sel    = ir_mem;
            modulus_sel   = ir_mod;
        end
        busy = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
               (state_q == S_WAIT)  || (state_q == S_ADV);
        done = (state_q == S_HALT);
        pc   = pc_q;
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a program-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_instr_sequencer;

    localparam int ADDR_W = 11;
    localparam int OP_W   = 8;
    localparam int PROC_W = 3;
    localparam int MEM_W  = 4;
    localparam int WW     = 3*OP_W + PROC_W + MEM_W + 1;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef INSTR_SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              start_eth;
    logic [WW-1:0]     program_data_eth;
    logic [ADDR_W-1:0] program_address_eth;
    logic              program_data_load_eth;
    logic              comp_exec;
    logic              ddr_exec;
    logic [OP_W-1:0]   instruction;
    logic [OP_W-1:0]   operand1;
    logic [OP_W-1:0]   operand2;
    logic [PROC_W-1:0] processor_sel;
    logic [MEM_W-1:0]  memory_sel;
    logic              modulus_sel;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              done;

    instr_sequencer #(.ADDR_W(ADDR_W), .OP_W(OP_W), .PROC_W(PROC_W), .MEM_W(MEM_W)) dut (
        .clk                              (clk),
        .rst_n                            (rst_n),
        .start_eth                        (start_eth),
        .program_data_eth                 (program_data_eth),
        .program_address_eth              (program_address_eth),
        .program_data_load_eth            (program_data_load_eth),
        .instruction_computation_executed (comp_exec),
        .instruction_ddr_executed         (ddr_exec),
        .instruction                      (instruction),
        .operand1                         (operand1),
        .operand2                         (operand2),
        .processor_sel                    (processor_sel),
        .memory_sel                       (memory_sel),
        .modulus_sel                      (modulus_sel),
        .pc                               (pc),
        .busy                             (busy),
        .done                             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Program-level model: mode 0 idle, 1 running, 2 halted; step = cycles into the current
    // instruction (0 fetch, 1 capture, 2 waiting, 3 advancing).
    int             m_mode;
    int             m_step;
    int             m_pc;
    int             m_cnt;
    bit             m_armed;
    logic [WW-1:0]  m_word;
    logic [WW-1:0]  m_mem [DEPTH];
    logic [7:0]     m_op;

    task automatic model_reset();
        m_mode = 0; m_step = 0; m_pc = 0; m_cnt = 0; m_armed = 0; m_word = '0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        model_reset();
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else if (!start_eth) begin
            model_reset();
        end else if (m_mode == 0) begin
            m_mode = 1; m_step = 0; m_pc = 0;
        end else if (m_mode == 1) begin
            m_op = m_word[7:0];
            if (m_step == 0) begin
                m_word = m_mem[m_pc];
                m_step = 1;
            end else if (m_step == 1) begin
                m_step = 2;
            end else if (m_step == 2) begin
                if (m_op == 8'd255) m_mode = 2;
                else if (m_op == 8'd0 || (LOOP_EN && m_op == 8'd254)) m_step = 3;
                else if (m_op == 8'd3 || m_op == 8'd4) begin
                    if (ddr_exec) m_step = 3;
                end else if (comp_exec) m_step = 3;
            end else begin
                if (LOOP_EN && m_op == 8'd254) begin
                    if (!m_armed && m_word[15:8] == 0) m_pc = (m_pc + 1) % DEPTH;
                    else if (!m_armed) begin
                        m_cnt = int'(m_word[15:8]) - 1; m_armed = 1;
                        m_pc = (m_pc - int'(m_word[23:16]) + DEPTH) % DEPTH;
                    end else if (m_cnt > 0) begin
                        m_cnt = m_cnt - 1;
                        m_pc = (m_pc - int'(m_word[23:16]) + DEPTH) % DEPTH;
                    end else begin
                        m_armed = 0; m_pc = (m_pc + 1) % DEPTH;
                    end
                end else begin
                    m_pc = (m_pc + 1) % DEPTH;
                end
                m_step = 0;
            end
        end
        if (program_data_load_eth) m_mem[program_address_eth] = program_data_eth;
    end

    logic [WW-1:0] exp_fields;
    logic [WW-1:0] got_fields;
    always @(negedge clk) begin
        if (!rst_n) model_reset();
        exp_fields = (m_mode == 1 && m_step == 2 && !(LOOP_EN && m_word[7:0] == 8'd254)) ? m_word : '0;
        got_fields = {modulus_sel, memory_sel, processor_sel, operand2, operand1, instruction};
        vectors++;
        if (got_fields !== exp_fields || int'(pc) != m_pc || busy !== (m_mode == 1) || done !== (m_mode == 2)) begin
            miscompares++;
            $display("FAIL cycle_model t=%0t got fields=%h pc=%0d busy=%b done=%b, want fields=%h pc=%0d busy=%b done=%b",
                     $time, got_fields, pc, busy, done, exp_fields, m_pc, (m_mode == 1), (m_mode == 2));
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] mk(input logic [7:0] op, input logic [7:0] o1, input logic [7:0] o2,
                                         input logic [2:0] pr, input logic [3:0] me, input logic md);
        return {md, me, pr, o2, o1, op};
    endfunction

    bit         auto_cmp;
    logic [7:0] issued [$];
    logic [7:0] prev_instr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_auto();
        if (auto_cmp) begin
            comp_exec = (instruction != 0);
            ddr_exec  = (instruction == 8'd3 || instruction == 8'd4);
        end
    endtask

    task automatic load_word(input int a, input logic [WW-1:0] w);
        program_address_eth   = ADDR_W'(a);
        program_data_eth      = w;
        program_data_load_eth = 1'b1;
        tick();
        program_data_load_eth = 1'b0;
    endtask

    task automatic run_until_done(input string name, input int budget, output int ticks, output int busy_cnt);
        ticks = 0; busy_cnt = 0; issued.delete(); prev_instr = 0;
        while (!done && ticks < budget) begin
            drive_auto();
            tick();
            ticks++;
            if (busy) busy_cnt++;
            if (instruction != 0 && prev_instr == 0) issued.push_back(instruction);
            prev_instr = instruction;
        end
        if (auto_cmp) begin comp_exec = 0; ddr_exec = 0; end
        check({name, "_reached_done"}, 32'(done), 32'd1);
    endtask

    task automatic run_until_pc(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (int'(pc) != target && n < budget) begin
            drive_auto();
            tick();
            n++;
        end
        check({name, "_reached_pc"}, 32'(pc), 32'(target));
    endtask

    task automatic stop_run();
        comp_exec = 0; ddr_exec = 0; auto_cmp = 0;
        start_eth = 0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int t, b, n5;

    initial begin
        rst_n = 0; start_eth = 0; program_data_eth = '0; program_address_eth = '0;
        program_data_load_eth = 0; comp_exec = 0; ddr_exec = 0; auto_cmp = 0;
        repeat (3) tick();
        rst_n = 1;
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_instr", 32'(instruction), 0);

        // Basic program: two computation ops then halt
        load_word(0, mk(8'd1, 8'h11, 8'h12, 3'd1, 4'd2, 1'b1));
        load_word(1, mk(8'd2, 8'h21, 8'h22, 3'd5, 4'd9, 1'b0));
        load_word(2, mk(8'd255, 8'h0, 8'h0, 3'd0, 4'd0, 1'b0));
        start_eth = 1; auto_cmp = 1;
        run_until_done("basic", 100, t, b);
        check("basic_n_issued", 32'(issued.size()), 3);
        if (issued.size() == 3) begin
            check("basic_issue0", 32'(issued[0]), 1);
            check("basic_issue1", 32'(issued[1]), 2);
            check("basic_issue2", 32'(issued[2]), 255);
        end
        check("basic_busy", 32'(busy), 0);
        check("basic_pc", 32'(pc), 2);
        stop_run();
        check("stop_pc", 32'(pc), 0);
        check("stop_done", 32'(done), 0);

        // NOP then halt with no completions: 7 busy cycles
        load_word(0, mk(8'd0, 8'h0, 8'h0, 3'd0, 4'd0, 1'b0));
        load_word(1, mk(8'd255, 8'h0, 8'h0, 3'd0, 4'd0, 1'b0));
        start_eth = 1;
        run_until_done("nop", 30, t, b);
        check("nop_busy_cycles", 32'(b), 7);
        check("nop_ticks", 32'(t), 8);
        check("nop_pc", 32'(pc), 1);
        stop_run();

        // DDR opcode ignores computation completion
        load_word(0, mk(8'd3, 8'h33, 8'h34, 3'd2, 4'd3, 1'b0));
        load_word(1, mk(8'd255, 8'h0, 8'h0, 3'd0, 4'd0, 1'b0));
        start_eth = 1; comp_exec = 1;
        repeat (10) tick();
        check("ddr_wait_instr", 32'(instruction), 3);
        check("ddr_wait_op1", 32'(operand1), 32'h33);
        check("ddr_wait_busy", 32'(busy), 1);
        ddr_exec = 1;
        tick();
        ddr_exec = 0;
        check("ddr_adv_instr", 32'(instruction), 0);
        check("ddr_adv_busy", 32'(busy), 1);
        tick();
        check("ddr_fetch_pc", 32'(pc), 1);
        run_until_done("ddr", 20, t, b);
        stop_run();

        // Load colliding with the fetch of address 0 returns the old word
        load_word(0, mk(8'd9, 8'h9, 8'h9, 3'd1, 4'd1, 1'b0));
        start_eth = 1;
        tick();
        program_address_eth = '0;
        program_data_eth = mk(8'd11, 8'hb, 8'hb, 3'd2, 4'd2, 1'b1);
        program_data_load_eth = 1;
        tick();
        program_data_load_eth = 0;
        auto_cmp = 1;
        run_until_done("collide", 50, t, b);
        if (issued.size() > 0) check("collide_old_word", 32'(issued[0]), 9);
        else check("collide_issued", 32'(issued.size()), 1);
        stop_run();
        start_eth = 1; auto_cmp = 1;
        run_until_done("collide_rerun", 50, t, b);
        if (issued.size() > 0) check("collide_new_word", 32'(issued[0]), 11);
        else check("collide_rerun_issued", 32'(issued.size()), 1);
        stop_run();

        // start drop and reset pulse while waiting
        start_eth = 1;
        repeat (3) tick();
        check("abort_wait_instr", 32'(instruction), 11);
        start_eth = 0;
        tick();
        check("abort_instr", 32'(instruction), 0);
        check("abort_pc", 32'(pc), 0);
        check("abort_busy", 32'(busy), 0);
        start_eth = 1;
        repeat (3) tick();
        check("restart_instr", 32'(instruction), 11);
        rst_n = 0;
        #1;
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_instr", 32'(instruction), 0);
        tick();
        rst_n = 1;
        repeat (3) tick();
        check("post_rst_instr", 32'(instruction), 11);
        check("post_rst_pc", 32'(pc), 0);
        stop_run();

`ifdef INSTR_SEQ_LOOP_EN
        // Hardware loop: op 5 runs three times
        load_word(0, mk(8'd5, 8'h5, 8'h5, 3'd0, 4'd0, 1'b0));
        load_word(1, mk(8'd254, 8'd2, 8'd1, 3'd0, 4'd0, 1'b0));
        load_word(2, mk(8'd255, 8'h0, 8'h0, 3'd0, 4'd0, 1'b0));
        start_eth = 1; auto_cmp = 1;
        run_until_done("loop", 200, t, b);
        n5 = 0;
        foreach (issued[i]) if (issued[i] == 8'd5) n5++;
        check("loop_issue_count", 32'(n5), 3);
        check("loop_pc", 32'(pc), 2);
        stop_run();
`else
        // Without the loop feature 254 waits for computation completion
        load_word(0, mk(8'd254, 8'd1, 8'd1, 3'd0, 4'd0, 1'b0));
        load_word(1, mk(8'd255, 8'h0, 8'h0, 3'd0, 4'd0, 1'b0));
        start_eth = 1;
        repeat (6) tick();
        check("op254_waits", 32'(instruction), 254);
        auto_cmp = 1;
        run_until_done("op254", 20, t, b);
        check("op254_pc", 32'(pc), 1);
        stop_run();
`endif

        // pc wraps from the last address back to 0
        for (int a = 0; a < DEPTH; a++)
            load_word(a, (a == 0) ? mk(8'd7, 8'h7, 8'h7, 3'd3, 4'd7, 1'b1) : '0);
        start_eth = 1; auto_cmp = 1;
        run_until_pc("wrap_top", DEPTH - 1, 10000);
        run_until_pc("wrap_zero", 0, 10);
        auto_cmp = 0; comp_exec = 0;
        repeat (3) tick();
        check("wrap_instr", 32'(instruction), 7);
        check("wrap_pc", 32'(pc), 0);
        stop_run();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
